mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one stalling, ready-handshaked, byte-addressed 32-bit memory between two requesters: instruction fetch (read-only) and data access (read/write). A single transaction is in flight at a time. Address, direction and write data are registered and held stable for the whole access. The block waits for the memory's ready, captures the read data and error, and returns a one-cycle done pulse to the winning requester. It sits between the core's fetch/memory stages and the memory model, and a watchdog aborts accesses that never become ready.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 64, max BUSY cycles without mem_ready before abort; legal range 2..65535

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; level, held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle completion pulse to fetch
if_rdata  out  DATA_W  fetch read data; valid when if_done=1
if_err  out  1  fetch error (memory err or timeout); valid when if_done=1
dm_req  in  1  data request; level, held until dm_done
dm_wr  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_done  out  1  one-cycle completion pulse to data port
dm_rdata  out  DATA_W  data read data; 0 for writes; valid when dm_done=1
dm_err  out  1  data error; valid when dm_done=1
mem_enable  out  1  memory enable
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, combinational, valid with mem_ready
mem_ready  in  1  memory accepted access this cycle
mem_err  in  1  memory reports misaligned access
timeout_seen  out  1  sticky flag, set on any watchdog abort, cleared only by rst

Behaviour:
- Reset (async): state=IDLE, last_grant=DM (so fetch wins the first tie), wait counter=0. All outputs are 0: done pulses, rdata, err, mem_* and timeout_seen.
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requests: grant the port opposite last_grant (round-robin).
- On grant: latch owner, addr, wr (forced 0 for fetch), wdata, and clear the wait counter. Then go to BUSY.
- BUSY drives mem_enable=1 and drives mem_wr, mem_addr and mem_wdata from the latched registers. The mem_* outputs are 0 in all other states.
- BUSY with mem_ready=1: capture the read data (0 if write) and mem_err into the owner's rdata/err registers, then go to RESP. A write commits in memory at that same edge.
- BUSY with mem_ready=0: increment the wait counter. When the counter equals TIMEOUT-1, capture err=1 and rdata=0, set timeout_seen, and go to RESP. The access is abandoned with no retry.
- RESP: pulse the owner's done for exactly one cycle and set last_grant=owner, then go to IDLE. The non-owner's done stays 0.
- Latency: request sampled at edge N, BUSY in cycle N+1, done in cycle N+2 if memory is ready in its first BUSY cycle. Each not-ready cycle adds one.
- Requester rule: the requester deasserts req in the done cycle. A req still high when IDLE is next sampled (the cycle after done) is a new request.
- Request inputs are ignored outside IDLE. Changes to a requester's addr/wdata mid-transaction have no effect.
- rdata and err hold their last captured values between done pulses.
- Reset mid-transaction: the transaction is dropped silently. No done is issued, and mem_enable falls asynchronously.
- Fairness: with both requests held continuously, grants alternate IF, DM, IF, DM, and so on.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - the owner encoding {OWN_IF=0, OWN_DM=1};
  - the constant DEFAULT_TIMEOUT=64.
- One sub-module, rr_pick2: a combinational 2-way round-robin picker taking the two reqs and last_grant and returning grant_valid and grant_owner. All FSM, latching and watchdog logic stays in mem_port_arbiter.

Test Plan:
- Fetch-only read at 0x0000_0010, mem_ready=1 in the first BUSY cycle, mem_rdata=0xDEAD_BEEF -> if_done in cycle N+2, if_rdata=0xDEADBEEF, if_err=0, mem_wr=0 throughout.
- Data write 0x1234_5678 to 0x100 with mem_ready low for 3 cycles -> mem_addr/mem_wdata stable for 4 BUSY cycles, dm_done at N+5, dm_rdata=0, dm_err=0.
- Both reqs held continuously from reset for 4 transactions -> grant order IF, DM, IF, DM, and each done is a single-cycle pulse.
- Data read at 0x101 with mem_ready=1 and mem_err=1 -> dm_done with dm_err=1, and the arbiter returns to IDLE.
- TIMEOUT=4 with mem_ready stuck at 0 -> after 4 BUSY cycles the requester gets done with err=1 and rdata=0, timeout_seen=1, and the next request is served normally.
- rst asserted mid-BUSY -> mem_enable drops the same cycle, no done pulse, and timeout_seen=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   // Arbiter FSM states: waiting for a request, access in flight, done pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // Which requester owns the current transaction.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Default watchdog limit in BUSY cycles without mem_ready.
   localparam int DEFAULT_TIMEOUT = 64;

endpackage : mem_arb_pkg

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that did not win last time.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req_if,
   input  logic req_dm,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_owner
);

   // Choose the winner from the current requests and the previous owner.
   always_comb begin
      grant_valid = 1'b0;
      grant_owner = OWN_IF;
      if (req_if && req_dm) begin
         grant_valid = 1'b1;
         grant_owner = (last_grant == OWN_IF) ? OWN_DM : OWN_IF;
      end else if (req_if) begin
         grant_valid = 1'b1;
         grant_owner = OWN_IF;
      end else if (req_dm) begin
         grant_valid = 1'b1;
         grant_owner = OWN_DM;
      end else begin
         grant_valid = 1'b0;
         grant_owner = OWN_IF;
      end
   end

endmodule : rr_pick2

// File: rtl/mem_port_arbiter.sv
// Shares one ready-handshaked memory between instruction fetch and data
// access. One transaction at a time; address, direction and write data are
// held in registers for the whole access, and a watchdog abandons accesses
// that never see mem_ready.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_err,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              mem_err,
   output logic              timeout_seen
);

   // Last wait-counter value before the watchdog fires.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_e            state_r;
   owner_e            owner_r;
   owner_e            last_grant_r;
   logic [15:0]       wait_cnt_r;
   logic              mem_enable_r;
   logic              mem_wr_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              if_done_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic              if_err_r;
   logic              dm_done_r;
   logic [DATA_W-1:0] dm_rdata_r;
   logic              dm_err_r;
   logic              timeout_seen_r;
   logic              grant_valid_s;
   logic              grant_owner_s;

   rr_pick2 u_pick (
      .req_if      (if_req),
      .req_dm      (dm_req),
      .last_grant  (last_grant_r),
      .grant_valid (grant_valid_s),
      .grant_owner (grant_owner_s)
   );

   // Arbiter FSM: grant, hold the memory access, capture the response and
   // pulse the owner's done. The mem_* registers double as the latched
   // request and read as zero outside BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         owner_r        <= OWN_IF;
         last_grant_r   <= OWN_DM;
         wait_cnt_r     <= 16'd0;
         mem_enable_r   <= 1'b0;
         mem_wr_r       <= 1'b0;
         mem_addr_r     <= {ADDR_W{1'b0}};
         mem_wdata_r    <= {DATA_W{1'b0}};
         if_done_r      <= 1'b0;
         if_rdata_r     <= {DATA_W{1'b0}};
         if_err_r       <= 1'b0;
         dm_done_r      <= 1'b0;
         dm_rdata_r     <= {DATA_W{1'b0}};
         dm_err_r       <= 1'b0;
         timeout_seen_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  owner_r      <= owner_e'(grant_owner_s);
                  wait_cnt_r   <= 16'd0;
                  mem_enable_r <= 1'b1;
                  if (grant_owner_s == OWN_DM) begin
                     mem_wr_r    <= dm_wr;
                     mem_addr_r  <= dm_addr;
                     mem_wdata_r <= dm_wdata;
                  end else begin
                     mem_wr_r    <= 1'b0;
                     mem_addr_r  <= if_addr;
                     mem_wdata_r <= {DATA_W{1'b0}};
                  end
                  state_r <= BUSY;
               end else begin
                  state_r <= IDLE;
               end
            end

            BUSY: begin
               if (mem_ready || (wait_cnt_r == WAIT_LAST)) begin
                  // Either the memory answered or the watchdog gave up;
                  // both end the access and release the memory bus.
                  mem_enable_r <= 1'b0;
                  mem_wr_r     <= 1'b0;
                  mem_addr_r   <= {ADDR_W{1'b0}};
                  mem_wdata_r  <= {DATA_W{1'b0}};
                  state_r      <= RESP;
                  if (owner_r == OWN_IF) begin
                     if_done_r  <= 1'b1;
                     if_rdata_r <= (mem_ready && !mem_wr_r) ? mem_rdata : {DATA_W{1'b0}};
                     if_err_r   <= mem_ready ? mem_err : 1'b1;
                  end else begin
                     dm_done_r  <= 1'b1;
                     dm_rdata_r <= (mem_ready && !mem_wr_r) ? mem_rdata : {DATA_W{1'b0}};
                     dm_err_r   <= mem_ready ? mem_err : 1'b1;
                  end
                  if (!mem_ready) begin
                     timeout_seen_r <= 1'b1;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end

            RESP: begin
               if_done_r    <= 1'b0;
               dm_done_r    <= 1'b0;
               last_grant_r <= owner_r;
               state_r      <= IDLE;
            end

            default: begin
               if_done_r    <= 1'b0;
               dm_done_r    <= 1'b0;
               mem_enable_r <= 1'b0;
               mem_wr_r     <= 1'b0;
               mem_addr_r   <= {ADDR_W{1'b0}};
               mem_wdata_r  <= {DATA_W{1'b0}};
               state_r      <= IDLE;
            end
         endcase
      end
   end

   assign if_done      = if_done_r;
   assign if_rdata     = if_rdata_r;
   assign if_err       = if_err_r;
   assign dm_done      = dm_done_r;
   assign dm_rdata     = dm_rdata_r;
   assign dm_err       = dm_err_r;
   assign mem_enable   = mem_enable_r;
   assign mem_wr       = mem_wr_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
   assign timeout_seen = timeout_seen_r;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. A default-TIMEOUT
// instance covers the handshake, arbitration and error paths; a second
// instance with TIMEOUT=4 covers the watchdog.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // Main instance stimulus and observation.
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dm_req = 1'b0;
   logic        dm_wr = 1'b0;
   logic [31:0] dm_addr = 32'h0;
   logic [31:0] dm_wdata = 32'h0;
   logic        dm_done;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        mem_err = 1'b0;
   logic        timeout_seen;

   // Watchdog instance stimulus and observation.
   logic        t_if_req = 1'b0;
   logic [31:0] t_if_addr = 32'h0;
   logic        t_if_done;
   logic [31:0] t_if_rdata;
   logic        t_if_err;
   logic        t_dm_done;
   logic [31:0] t_dm_rdata;
   logic        t_dm_err;
   logic        t_mem_enable;
   logic        t_mem_wr;
   logic [31:0] t_mem_addr;
   logic [31:0] t_mem_wdata;
   logic [31:0] t_mem_rdata = 32'h0;
   logic        t_mem_ready = 1'b0;
   logic        t_timeout_seen;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
      .timeout_seen(timeout_seen)
   );

   mem_port_arbiter #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst),
      .if_req(t_if_req), .if_addr(t_if_addr), .if_done(t_if_done), .if_rdata(t_if_rdata), .if_err(t_if_err),
      .dm_req(1'b0), .dm_wr(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_done(t_dm_done), .dm_rdata(t_dm_rdata), .dm_err(t_dm_err),
      .mem_enable(t_mem_enable), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
      .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready), .mem_err(1'b0),
      .timeout_seen(t_timeout_seen)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if ({if_done, if_err, dm_done, dm_err, mem_enable, mem_wr, timeout_seen} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {if_done, if_err, dm_done, dm_err, mem_enable, mem_wr, timeout_seen});
      end
      n_checks++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'h0) begin
         n_errors++;
         $display("FAIL reset_data: got %h required 0", {if_rdata, dm_rdata, mem_addr, mem_wdata});
      end
      n_checks++;
      if ({t_mem_enable, t_if_done, t_timeout_seen} !== 3'b0) begin
         n_errors++;
         $display("FAIL reset_to_inst: got %b required 000", {t_mem_enable, t_if_done, t_timeout_seen});
      end
      rst = 1'b0;
   endtask

   // Both requests held from reset: fetch wins the first tie, then alternate.
   task automatic test_fairness();
      logic        exp_dm;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      if_addr   = 32'h0000_0200;
      dm_addr   = 32'h0000_0300;
      dm_wr     = 1'b0;
      mem_ready = 1'b1;
      mem_err   = 1'b0;
      if_req    = 1'b1;
      dm_req    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_dm   = ((k % 2) == 1);
         exp_addr = exp_dm ? 32'h0000_0300 : 32'h0000_0200;
         exp_data = 32'hA000_0000 + 32'(k);
         mem_rdata = exp_data;
         step();
         n_checks++;
         if ({mem_enable, mem_addr} !== {1'b1, exp_addr}) begin
            n_errors++;
            $display("FAIL fair_grant%0d: got en=%b addr=%h required en=1 addr=%h", k, mem_enable, mem_addr, exp_addr);
         end
         step();
         n_checks++;
         if ({if_done, dm_done} !== {~exp_dm, exp_dm}) begin
            n_errors++;
            $display("FAIL fair_done%0d: got if=%b dm=%b required if=%b dm=%b", k, if_done, dm_done, ~exp_dm, exp_dm);
         end
         n_checks++;
         if ((exp_dm ? dm_rdata : if_rdata) !== exp_data) begin
            n_errors++;
            $display("FAIL fair_rdata%0d: got %h required %h", k, exp_dm ? dm_rdata : if_rdata, exp_data);
         end
         if (k == 3) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end
         step();
         n_checks++;
         if ({if_done, dm_done} !== 2'b00) begin
            n_errors++;
            $display("FAIL fair_pulse%0d: got if=%b dm=%b required 0 0", k, if_done, dm_done);
         end
      end
   endtask

   task automatic test_fetch_read();
      if_addr   = 32'h0000_0010;
      mem_rdata = 32'hDEAD_BEEF;
      mem_ready = 1'b1;
      mem_err   = 1'b0;
      if_req    = 1'b1;
      step();
      n_checks++;
      if ({mem_enable, mem_wr, mem_addr, if_done} !== {1'b1, 1'b0, 32'h0000_0010, 1'b0}) begin
         n_errors++;
         $display("FAIL fetch_busy: got en=%b wr=%b addr=%h done=%b required 1 0 00000010 0",
                  mem_enable, mem_wr, mem_addr, if_done);
      end
      step();
      n_checks++;
      if ({if_done, if_err, if_rdata, dm_done} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
         n_errors++;
         $display("FAIL fetch_done: got done=%b err=%b rdata=%h dm_done=%b required 1 0 deadbeef 0",
                  if_done, if_err, if_rdata, dm_done);
      end
      n_checks++;
      if ({mem_enable, mem_wr} !== 2'b00) begin
         n_errors++;
         $display("FAIL fetch_mem_idle: got en=%b wr=%b required 0 0", mem_enable, mem_wr);
      end
      if_req    = 1'b0;
      mem_rdata = 32'h0;
      step();
      n_checks++;
      if ({if_done, if_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
         n_errors++;
         $display("FAIL fetch_hold: got done=%b rdata=%h required 0 deadbeef", if_done, if_rdata);
      end
   endtask

   // Write with three not-ready cycles; request fields change mid-access.
   task automatic test_data_write_wait();
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      dm_wr     = 1'b1;
      dm_addr   = 32'h0000_0100;
      dm_wdata  = 32'h1234_5678;
      dm_req    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({mem_enable, mem_wr, mem_addr, mem_wdata, dm_done} !==
             {1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0}) begin
            n_errors++;
            $display("FAIL write_busy%0d: got en=%b wr=%b addr=%h wdata=%h done=%b required 1 1 00000100 12345678 0",
                     i, mem_enable, mem_wr, mem_addr, mem_wdata, dm_done);
         end
         dm_addr  = 32'h0000_0BAD;
         dm_wdata = 32'h0BAD_0BAD;
         if (i == 3) mem_ready = 1'b1;
      end
      step();
      n_checks++;
      if ({dm_done, dm_err, dm_rdata, if_done} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL write_done: got done=%b err=%b rdata=%h if_done=%b required 1 0 00000000 0",
                  dm_done, dm_err, dm_rdata, if_done);
      end
      dm_req = 1'b0;
      dm_wr  = 1'b0;
      step();
   endtask

   task automatic test_data_err();
      dm_wr     = 1'b0;
      dm_addr   = 32'h0000_0101;
      mem_rdata = 32'h0000_0055;
      mem_ready = 1'b1;
      mem_err   = 1'b1;
      dm_req    = 1'b1;
      step();
      step();
      n_checks++;
      if ({dm_done, dm_err, dm_rdata} !== {1'b1, 1'b1, 32'h0000_0055}) begin
         n_errors++;
         $display("FAIL err_done: got done=%b err=%b rdata=%h required 1 1 00000055", dm_done, dm_err, dm_rdata);
      end
      dm_req  = 1'b0;
      mem_err = 1'b0;
      step();
      n_checks++;
      if ({mem_enable, dm_done} !== 2'b00) begin
         n_errors++;
         $display("FAIL err_idle: got en=%b done=%b required 0 0", mem_enable, dm_done);
      end
      // A follow-up fetch is served normally.
      if_addr   = 32'h0000_0020;
      mem_rdata = 32'h0000_1111;
      if_req    = 1'b1;
      step();
      step();
      n_checks++;
      if ({if_done, if_err, if_rdata} !== {1'b1, 1'b0, 32'h0000_1111}) begin
         n_errors++;
         $display("FAIL err_next: got done=%b err=%b rdata=%h required 1 0 00001111", if_done, if_err, if_rdata);
      end
      if_req = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      // Normal fetch first so the abort visibly clears rdata.
      t_if_addr   = 32'h0000_0040;
      t_mem_rdata = 32'hCAFE_F00D;
      t_mem_ready = 1'b1;
      t_if_req    = 1'b1;
      step();
      step();
      n_checks++;
      if ({t_if_done, t_if_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
         n_errors++;
         $display("FAIL to_pre: got done=%b rdata=%h required 1 cafef00d", t_if_done, t_if_rdata);
      end
      t_if_req = 1'b0;
      step();
      t_mem_ready = 1'b0;
      t_if_req    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({t_mem_enable, t_if_done, t_timeout_seen} !== 3'b100) begin
            n_errors++;
            $display("FAIL to_busy%0d: got en=%b done=%b seen=%b required 1 0 0", i, t_mem_enable, t_if_done, t_timeout_seen);
         end
      end
      step();
      n_checks++;
      if ({t_if_done, t_if_err, t_if_rdata, t_timeout_seen, t_mem_enable} !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL to_abort: got done=%b err=%b rdata=%h seen=%b en=%b required 1 1 00000000 1 0",
                  t_if_done, t_if_err, t_if_rdata, t_timeout_seen, t_mem_enable);
      end
      t_if_req = 1'b0;
      step();
      t_mem_ready = 1'b1;
      t_mem_rdata = 32'h0000_7777;
      t_if_req    = 1'b1;
      step();
      step();
      n_checks++;
      if ({t_if_done, t_if_err, t_if_rdata, t_timeout_seen} !== {1'b1, 1'b0, 32'h0000_7777, 1'b1}) begin
         n_errors++;
         $display("FAIL to_next: got done=%b err=%b rdata=%h seen=%b required 1 0 00007777 1",
                  t_if_done, t_if_err, t_if_rdata, t_timeout_seen);
      end
      t_if_req = 1'b0;
      step();
      n_checks++;
      if (timeout_seen !== 1'b0) begin
         n_errors++;
         $display("FAIL main_seen: got %b required 0", timeout_seen);
      end
   endtask

   task automatic test_reset_mid_busy();
      mem_ready = 1'b0;
      dm_wr     = 1'b0;
      dm_addr   = 32'h0000_0400;
      dm_req    = 1'b1;
      step();
      n_checks++;
      if (mem_enable !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_pre_busy: got en=%b required 1", mem_enable);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mem_enable, dm_done, timeout_seen, t_timeout_seen} !== 4'b0000) begin
         n_errors++;
         $display("FAIL rst_async: got en=%b done=%b seen=%b t_seen=%b required 0 0 0 0",
                  mem_enable, dm_done, timeout_seen, t_timeout_seen);
      end
      dm_req    = 1'b0;
      mem_ready = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({mem_enable, dm_done, if_done} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_no_done%0d: got en=%b dm_done=%b if_done=%b required 0 0 0", i, mem_enable, dm_done, if_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_fetch_read();
      test_data_write_wait();
      test_data_err();
      test_timeout();
      test_reset_mid_busy();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
